// File: rtl/guess_scorer_pkg.sv
// Shared definitions for the guess scorer: board geometry, the scorer FSM
// state encoding and the board result record that the scorer fills in.
package guess_scorer_pkg;

  localparam int MAX_PINS_COUNT = 20;
  localparam int PIN_COLOR_W    = 5;
  localparam int PIN_POS_W      = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GREEN  = 2'd1,
    YELLOW = 2'd2,
    DONE   = 2'd3
  } scorer_state_e;

  // Scoring result for one guess row on the board.
  typedef struct packed {
    logic [PIN_POS_W-1:0]      calculated_green;
    logic [PIN_POS_W-1:0]      calculated_yellow;
    logic [MAX_PINS_COUNT-1:0] analyzed_guess;
    logic [MAX_PINS_COUNT-1:0] analyzed_secret;
  } board_t;

  // Color stored at position idx of a packed pin row.
  function automatic logic [PIN_COLOR_W-1:0] pin_color(
    input logic [MAX_PINS_COUNT*PIN_COLOR_W-1:0] pins,
    input logic [PIN_POS_W-1:0]                  idx
  );
    return pins[int'(idx)*PIN_COLOR_W +: PIN_COLOR_W];
  endfunction

endpackage

// File: rtl/guess_scorer_if.sv
// Request/result bundle of the guess scorer.
// Handshake: the requester raises start for one cycle while busy is low;
// the request (pins_count, guess, secret) is captured on that edge. A start
// seen while busy is high is dropped. The scorer answers with a one-cycle
// done pulse; green, yellow and both masks are valid from done until the
// next accepted start.
interface guess_scorer_if import guess_scorer_pkg::*; #(
  parameter int PINS_MAX = MAX_PINS_COUNT,
  parameter int COLOR_W  = PIN_COLOR_W,
  parameter int POS_W    = PIN_POS_W
);
  logic                        start;
  logic [POS_W-1:0]            pins_count;
  logic [PINS_MAX*COLOR_W-1:0] guess;
  logic [PINS_MAX*COLOR_W-1:0] secret;
  logic                        busy;
  logic                        done;
  logic [POS_W-1:0]            green;
  logic [POS_W-1:0]            yellow;
  logic [PINS_MAX-1:0]         guess_mask;
  logic [PINS_MAX-1:0]         secret_mask;

  modport master (
    output start, pins_count, guess, secret,
    input  busy, done, green, yellow, guess_mask, secret_mask
  );

  modport slave (
    input  start, pins_count, guess, secret,
    output busy, done, green, yellow, guess_mask, secret_mask
  );
endinterface

// File: rtl/guess_scorer.sv
// Sequential guess scorer: counts exact matches in one pass over the
// positions, then searches unconsumed secret pins for each unconsumed guess
// pin one position per cycle. Operands are latched at start so the inputs
// may change freely while scoring is in progress.
module guess_scorer import guess_scorer_pkg::*; #(
  parameter int PINS_MAX = MAX_PINS_COUNT,
  parameter int COLOR_W  = PIN_COLOR_W,
  parameter int POS_W    = PIN_POS_W
) (
  input  logic          clk,
  input  logic          reset,
  guess_scorer_if.slave bus,
  output scorer_state_e state_dbg
);

  localparam logic [POS_W-1:0] POS_ONE = 1;

  scorer_state_e               state_q;
  logic                        busy_q;
  logic                        done_q;
  board_t                      board_q;
  logic [PINS_MAX*COLOR_W-1:0] guess_q;
  logic [PINS_MAX*COLOR_W-1:0] secret_q;
  logic [POS_W-1:0]            n_q;
  logic [POS_W-1:0]            i_q;
  logic [POS_W-1:0]            j_q;

  logic [POS_W-1:0]   n_eff;
  logic [COLOR_W-1:0] guess_i;
  logic [COLOR_W-1:0] secret_i;
  logic [COLOR_W-1:0] secret_j;
  logic               last_i;
  logic               last_j;
  logic               hit_j;

  // Clamp the requested width to the board and pick out the pins under test.
  always_comb begin
    n_eff    = (bus.pins_count > POS_W'(PINS_MAX)) ? POS_W'(PINS_MAX) : bus.pins_count;
    guess_i  = pin_color(guess_q, i_q);
    secret_i = pin_color(secret_q, i_q);
    secret_j = pin_color(secret_q, j_q);
    last_i   = (i_q == n_q - POS_ONE);
    last_j   = (j_q == n_q - POS_ONE);
    hit_j    = !board_q.analyzed_secret[j_q] && (guess_i == secret_j);
  end

  // Scoring FSM: IDLE -> GREEN (one position per cycle) -> YELLOW -> DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      board_q  <= '0;
      guess_q  <= '0;
      secret_q <= '0;
      n_q      <= '0;
      i_q      <= '0;
      j_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            guess_q  <= bus.guess;
            secret_q <= bus.secret;
            n_q      <= n_eff;
            board_q  <= '0;
            i_q      <= '0;
            j_q      <= '0;
            busy_q   <= 1'b1;
            if (n_eff == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= GREEN;
            end
          end
        end

        GREEN: begin
          if (guess_i == secret_i) begin
            board_q.calculated_green       <= board_q.calculated_green + POS_ONE;
            board_q.analyzed_guess[i_q]    <= 1'b1;
            board_q.analyzed_secret[i_q]   <= 1'b1;
          end
          if (last_i) begin
            state_q <= YELLOW;
            i_q     <= '0;
            j_q     <= '0;
          end else begin
            i_q <= i_q + POS_ONE;
          end
        end

        YELLOW: begin
          // A guess pin is finished when it was already consumed, when it
          // finds a free secret pin of its color, or when the search runs out.
          if (board_q.analyzed_guess[i_q] || hit_j || last_j) begin
            if (!board_q.analyzed_guess[i_q] && hit_j) begin
              board_q.calculated_yellow      <= board_q.calculated_yellow + POS_ONE;
              board_q.analyzed_guess[i_q]    <= 1'b1;
              board_q.analyzed_secret[j_q]   <= 1'b1;
            end
            j_q <= '0;
            if (last_i) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              i_q <= i_q + POS_ONE;
            end
          end else begin
            j_q <= j_q + POS_ONE;
          end
        end

        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  // Results come straight from the board record.
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.green       = board_q.calculated_green;
  assign bus.yellow      = board_q.calculated_yellow;
  assign bus.guess_mask  = board_q.analyzed_guess;
  assign bus.secret_mask = board_q.analyzed_secret;
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_guess_scorer.sv
// Bench for guess_scorer: directed requests push their hand-computed result
// into an expected queue; an independent monitor pops and compares on done.
module tb_guess_scorer;
  import guess_scorer_pkg::*;

  localparam int PM = MAX_PINS_COUNT;
  localparam int CW = PIN_COLOR_W;
  localparam int PW = PIN_POS_W;

  typedef struct packed {
    logic [PW-1:0] green;
    logic [PW-1:0] yellow;
    logic [PM-1:0] gmask;
    logic [PM-1:0] smask;
    logic [15:0]   lat;
  } exp_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  guess_scorer_if bus ();
  scorer_state_e  state_dbg;

  guess_scorer dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;
  int   done_count = 0;
  exp_t exp_q[$];
  int   start_q[$];
  exp_t last_exp;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!reset && bus.done) begin
      exp_t e;
      int   s;
      done_count++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(bus.done), 32'd0);
      end else begin
        e = exp_q.pop_front();
        s = start_q.pop_front();
        check("green",       32'(bus.green),       32'(e.green));
        check("yellow",      32'(bus.yellow),      32'(e.yellow));
        check("guess_mask",  32'(bus.guess_mask),  32'(e.gmask));
        check("secret_mask", 32'(bus.secret_mask), 32'(e.smask));
        check("latency",     32'(cyc - s - 1),     32'(e.lat));
      end
    end
  end

  // ---------------- driver helpers ----------------
  function automatic logic [PM*CW-1:0] pack4(input int a, input int b, input int c, input int d);
    logic [PM*CW-1:0] v;
    v = '0;
    v[0*CW +: CW] = CW'(a);
    v[1*CW +: CW] = CW'(b);
    v[2*CW +: CW] = CW'(c);
    v[3*CW +: CW] = CW'(d);
    return v;
  endfunction

  function automatic exp_t mk_exp(input int g, input int y, input int gm, input int sm, input int lat);
    exp_t e;
    e.green  = PW'(g);
    e.yellow = PW'(y);
    e.gmask  = PM'(gm);
    e.smask  = PM'(sm);
    e.lat    = 16'(lat);
    return e;
  endfunction

  // Presents one request for a single cycle; returns at the negedge after
  // the start-sampling edge.
  task automatic drive_start(input int n, input logic [PM*CW-1:0] g,
                             input logic [PM*CW-1:0] s, input exp_t e, input bit expect_done);
    @(negedge clk);
    bus.pins_count = PW'(n);
    bus.guess      = g;
    bus.secret     = s;
    bus.start      = 1'b1;
    if (expect_done) begin
      exp_q.push_back(e);
      start_q.push_back(cyc);
      last_exp = e;
    end
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  // Results must hold after done until the next start.
  task automatic check_hold();
    repeat (3) @(negedge clk);
    check("hold_green",  32'(bus.green),       32'(last_exp.green));
    check("hold_yellow", 32'(bus.yellow),      32'(last_exp.yellow));
    check("hold_gmask",  32'(bus.guess_mask),  32'(last_exp.gmask));
    check("hold_smask",  32'(bus.secret_mask), 32'(last_exp.smask));
    check("idle_busy",   32'(bus.busy),        32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  32'(bus.busy),        32'd0);
    check({tag, "_done"},  32'(bus.done),        32'd0);
    check({tag, "_green"}, 32'(bus.green),       32'd0);
    check({tag, "_yel"},   32'(bus.yellow),      32'd0);
    check({tag, "_gmask"}, 32'(bus.guess_mask),  32'd0);
    check({tag, "_smask"}, 32'(bus.secret_mask), 32'd0);
    check({tag, "_state"}, 32'(state_dbg),       32'(IDLE));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [PM*CW-1:0] row;
    int               dc;

    bus.start      = 1'b0;
    bus.pins_count = '0;
    bus.guess      = '0;
    bus.secret     = '0;
    last_exp       = '0;
    reset          = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("rst");
    reset = 1'b0;

    // All exact: 4 GREEN + 4 masked YELLOW cycles.
    drive_start(4, pack4(1, 2, 3, 4), pack4(1, 2, 3, 4), mk_exp(4, 0, 'hF, 'hF, 8), 1'b1);
    check("busy_after_start", 32'(bus.busy), 32'd1);
    wait_drain();
    check_hold();

    // Reversed: 4 GREEN + 4+3+2+1 YELLOW cycles.
    drive_start(4, pack4(4, 3, 2, 1), pack4(1, 2, 3, 4), mk_exp(0, 4, 'hF, 'hF, 14), 1'b1);
    wait_drain();
    check_hold();

    // Duplicates: 4 GREEN + 1 + 3 + 2 + 4 YELLOW cycles.
    drive_start(4, pack4(1, 2, 1, 5), pack4(1, 1, 2, 2), mk_exp(1, 2, 'h7, 'h7, 14), 1'b1);
    wait_drain();
    check_hold();

    // N=2: positions beyond N must be ignored and their masks stay clear.
    drive_start(2, pack4(7, 3, 9, 9), pack4(3, 7, 9, 9), mk_exp(0, 2, 'h3, 'h3, 5), 1'b1);
    wait_drain();
    check_hold();

    // N=0: done right after the start edge.
    drive_start(0, pack4(1, 2, 3, 4), pack4(1, 2, 3, 4), mk_exp(0, 0, 0, 0, 0), 1'b1);
    wait_drain();
    check_hold();

    // N=31 clamps to 20: every position matches exactly.
    row = '0;
    for (int p = 0; p < PM; p++) row[p*CW +: CW] = CW'(p);
    drive_start(31, row, row, mk_exp(20, 0, 'hFFFFF, 'hFFFFF, 40), 1'b1);
    wait_drain();
    check_hold();

    // Second start and input changes while busy are ignored.
    dc = done_count;
    drive_start(4, pack4(1, 2, 1, 5), pack4(1, 1, 2, 2), mk_exp(1, 2, 'h7, 'h7, 14), 1'b1);
    repeat (2) @(negedge clk);
    bus.start      = 1'b1;
    bus.pins_count = PW'(2);
    bus.guess      = pack4(9, 9, 9, 9);
    bus.secret     = pack4(9, 9, 9, 9);
    @(negedge clk);
    bus.start = 1'b0;
    wait_drain();
    repeat (10) @(negedge clk);
    check("single_done", 32'(done_count - dc), 32'd1);
    check("busy_restart_green", 32'(bus.green), 32'd1);

    // Reset in the middle of YELLOW aborts without a done pulse.
    dc = done_count;
    drive_start(4, pack4(1, 2, 1, 5), pack4(1, 1, 2, 2), '0, 1'b0);
    repeat (9) @(negedge clk);
    check("mid_state", 32'(state_dbg), 32'(YELLOW));
    check("mid_green", 32'(bus.green), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("abort");
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("abort_no_done", 32'(done_count - dc), 32'd0);

    // Reset wins over a simultaneous start.
    @(negedge clk);
    bus.pins_count = PW'(4);
    bus.guess      = pack4(1, 2, 3, 4);
    bus.secret     = pack4(1, 2, 3, 4);
    bus.start      = 1'b1;
    reset          = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    reset     = 1'b0;
    check_all_zero("rst_vs_start");
    repeat (20) @(negedge clk);
    check("rst_vs_start_no_done", 32'(done_count - dc), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passes, checks);
    $fatal(1, "watchdog");
  end

endmodule
